// File: rtl/stream_width_down.sv
// stream_width_down: tkeep-aware stream downsizer. Each accepted input word
// of IN_BYTES is replayed as up to RATIO sub-beats of OUT_BYTES, LSB first.
//
// Optional feature macro: STREAM_WIDTH_DOWN_TRIM_EN
//   defined   : trailing sub-beats of a packet's last word whose tkeep slice
//               is all zero are dropped.
//   undefined : every word yields exactly RATIO sub-beats.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   io_dataIn_valid/_ready              input handshake
//   io_dataIn_payload_last              last word of packet
//   io_dataIn_payload_fragment_data     8*IN_BYTES, byte 0 at [7:0]
//   io_dataIn_payload_fragment_tkeep    IN_BYTES byte enables
//   io_dataOut_valid/_ready             output handshake
//   io_dataOut_payload_last             last sub-beat of packet
//   io_dataOut_payload_fragment_data    8*OUT_BYTES sub-beat data
//   io_dataOut_payload_fragment_tkeep   OUT_BYTES sub-beat byte enables
module stream_width_down #(
  parameter int unsigned IN_BYTES = 64,
  parameter int unsigned RATIO    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_dataIn_valid,
  output logic                      io_dataIn_ready,
  input  logic                      io_dataIn_payload_last,
  input  logic [8*IN_BYTES-1:0]     io_dataIn_payload_fragment_data,
  input  logic [IN_BYTES-1:0]       io_dataIn_payload_fragment_tkeep,
  output logic                      io_dataOut_valid,
  input  logic                      io_dataOut_ready,
  output logic                      io_dataOut_payload_last,
  output logic [8*(IN_BYTES/RATIO)-1:0] io_dataOut_payload_fragment_data,
  output logic [IN_BYTES/RATIO-1:0] io_dataOut_payload_fragment_tkeep
);

  localparam int unsigned OUT_BYTES = IN_BYTES / RATIO;
  localparam int unsigned IN_W      = 8 * IN_BYTES;
  localparam int unsigned OUT_W     = 8 * OUT_BYTES;
  localparam int unsigned IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e               state_q;
  logic [IN_W-1:0]      data_q;
  logic [IN_BYTES-1:0]  tkeep_q;
  logic                 last_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     last_idx_q;

  logic [IN_W-1:0]      data_d;
  logic [IN_BYTES-1:0]  tkeep_d;
  logic [IDX_W-1:0]     cap_last_idx_c;
  logic                 final_c;
  logic                 in_fire_c;
  logic                 out_fire_c;

  // Handshake decode; ready is combinational so the final sub-beat and the
  // next word transfer in the same cycle.
  assign final_c         = (idx_q == last_idx_q);
  assign io_dataIn_ready = (state_q == EMPTY) | (io_dataOut_ready & final_c);
  assign in_fire_c       = io_dataIn_valid & io_dataIn_ready;
  assign out_fire_c      = (state_q == HOLD) & io_dataOut_ready;

  // The holding register is shifted down one sub-beat per handshake, so the
  // current sub-beat always sits in the low bits.
  assign io_dataOut_valid                  = (state_q == HOLD);
  assign io_dataOut_payload_last           = last_q & final_c;
  assign io_dataOut_payload_fragment_data  = data_q[OUT_W-1:0];
  assign io_dataOut_payload_fragment_tkeep = tkeep_q[OUT_BYTES-1:0];

  // Index of the final sub-beat for the word being captured.
  always_comb begin
    cap_last_idx_c = IDX_W'(RATIO - 1);
`ifdef STREAM_WIDTH_DOWN_TRIM_EN
    if (io_dataIn_payload_last) begin
      cap_last_idx_c = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (|io_dataIn_payload_fragment_tkeep[k*OUT_BYTES +: OUT_BYTES]) begin
          cap_last_idx_c = IDX_W'(k);
        end
      end
    end
`endif
  end

  // Next holding-register contents: fresh word on load, else shift down.
  always_comb begin
    data_d  = data_q >> OUT_W;
    tkeep_d = tkeep_q >> OUT_BYTES;
    if (in_fire_c) begin
      data_d  = io_dataIn_payload_fragment_data;
      tkeep_d = io_dataIn_payload_fragment_tkeep;
    end
  end

  // EMPTY/HOLD control and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      data_q     <= '0;
      tkeep_q    <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            state_q    <= HOLD;
            data_q     <= data_d;
            tkeep_q    <= tkeep_d;
            last_q     <= io_dataIn_payload_last;
            idx_q      <= '0;
            last_idx_q <= cap_last_idx_c;
          end
        end
        HOLD: begin
          if (out_fire_c) begin
            if (final_c) begin
              idx_q <= '0;
              if (in_fire_c) begin
                data_q     <= data_d;
                tkeep_q    <= tkeep_d;
                last_q     <= io_dataIn_payload_last;
                last_idx_q <= cap_last_idx_c;
              end else begin
                state_q <= EMPTY;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              data_q  <= data_d;
              tkeep_q <= tkeep_d;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
